// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus handshake sequencer driving the transmit side of the Uart block.
// Holds tx_data for the whole frame and always presents a clean 0->1 start edge.
module uart_tx_feeder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    input  logic              clr_overflow_i,
    output logic              uart_start_o,
    output logic [7:0]        uart_tx_data_o,
    input  logic              uart_tx_done_i,
    output logic              sent_pulse_o,
    output logic              busy_o
);

    localparam int unsigned       TimerW    = 8;
    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [TimerW-1:0] AckLast   = TimerW'(ACK_TIMEOUT - 1);
    localparam logic [TimerW-1:0] GapLast   = TimerW'(GAP_CYCLES - 1);
    // Extra ARM cycle after a pop so tx_data is settled a full cycle before start's low cycle.
    localparam logic [TimerW-1:0] ArmSettle = TimerW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWaitAck,
        StBusy,
        StGap
    } state_e;

    state_e             state_q;
    logic               start_q;
    logic [7:0]         tx_data_q;
    logic               sent_pulse_q;
    logic               busy_q;
    logic [TimerW-1:0]  timer_q;

    logic [7:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               overflow_q, overflow_d;
    logic               push;
    logic               pop;
    logic [7:0]         head;

    always_comb begin
        push     = wr_en_i && !full_q;
        pop      = (state_q == StIdle) && !empty_q && uart_tx_done_i;
        head     = mem_q[rd_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == FullCount);
        empty_d = (count_d == '0);

        // A dropped write in the same cycle as a clear keeps the flag set.
        overflow_d = overflow_q;
        if (clr_overflow_i) begin
            overflow_d = 1'b0;
        end
        if (wr_en_i && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            start_q      <= 1'b0;
            tx_data_q    <= 8'h00;
            sent_pulse_q <= 1'b0;
            busy_q       <= 1'b0;
            timer_q      <= '0;
        end else begin
            sent_pulse_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        tx_data_q <= head;
                        timer_q   <= ArmSettle;
                        busy_q    <= 1'b1;
                        state_q   <= StArm;
                    end
                end
                StArm: begin
                    start_q <= 1'b0;
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else begin
                        start_q <= 1'b1;
                        state_q <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (!uart_tx_done_i) begin
                        start_q <= 1'b0;
                        state_q <= StBusy;
                    end else if (timer_q == AckLast) begin
                        // No acknowledge: drop start for one cycle and retry the same byte.
                        start_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= StArm;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StBusy: begin
                    start_q <= 1'b0;
                    if (uart_tx_done_i) begin
                        sent_pulse_q <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= StGap;
                    end
                end
                StGap: begin
                    if (timer_q == GapLast) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign uart_start_o   = start_q;
    assign uart_tx_data_o = tx_data_q;
    assign sent_pulse_o   = sent_pulse_q;
    assign busy_o         = busy_q;

    a_count_range: assert property (@(posedge clk) disable iff (reset) count_q <= FullCount);
    a_full_empty: assert property (@(posedge clk) disable iff (reset) !(full_q && empty_q));
    a_arm_low: assert property (@(posedge clk) disable iff (reset)
        (state_q == StArm) |-> !start_q);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder with a behavioural Uart transmitter model.
module tb_uart_tx_feeder;

    localparam int Depth      = 16;
    localparam int AckTimeout = 8;
    localparam int GapCycles  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clr_ov = 1'b0;
    logic       tx_done = 1'b1;
    logic       full, empty, overflow, start, sent_pulse, busy;
    logic [4:0] count;
    logic [7:0] tx_data;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Uart model state
    bit         hold_low = 1'b0;
    bit         ignore_start = 1'b0;
    int         frame_left = 0;
    logic [7:0] cur_byte = 8'h00;
    int         data_err = 0;
    int         pulses = 0;
    logic       prev_start = 1'b0;
    logic [7:0] sent_q[$];
    int         rise_q[$];
    int         end_q[$];

    uart_tx_feeder #(
        .DEPTH(Depth), .ADDR_W(4), .ACK_TIMEOUT(AckTimeout), .GAP_CYCLES(GapCycles)
    ) dut (
        .clk(clk), .reset(reset), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(overflow),
        .clr_overflow_i(clr_ov), .uart_start_o(start), .uart_tx_data_o(tx_data),
        .uart_tx_done_i(tx_done), .sent_pulse_o(sent_pulse), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: idle = done high; a high start while idle launches a frame of random length.
    always @(negedge clk) begin
        if (start && !prev_start) rise_q.push_back(cyc);
        prev_start = start;
        if (sent_pulse) pulses++;
        if (reset) begin
            frame_left = 0;
            tx_done = !hold_low;
        end else if (hold_low) begin
            tx_done = 1'b0;
        end else if (frame_left != 0) begin
            if (tx_data !== cur_byte) data_err++;
            frame_left--;
            if (frame_left == 0) begin
                tx_done = 1'b1;
                end_q.push_back(cyc);
            end
        end else begin
            tx_done = 1'b1;
            if (start && !ignore_start) begin
                cur_byte = tx_data;
                sent_q.push_back(tx_data);
                frame_left = 6 + int'($urandom_range(8, 0));
                tx_done = 1'b0;
            end
        end
    end

    task automatic wait_done(input int n_sent, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (sent_q.size() >= n_sent && frame_left == 0 && !busy && empty) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({start, tx_data, sent_pulse, busy} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_outputs start=%b data=%h pulse=%b busy=%b want 0/00/0/0",
                     start, tx_data, sent_pulse, busy);
        end
        n_cmp++;
        if ({count, empty, full, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fifo count=%0d empty=%b full=%b ovf=%b want 0/1/0/0",
                     count, empty, full, overflow);
        end
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic test_single();
        int sb = sent_q.size();
        int pb = pulses;
        int db = data_err;
        logic [2:0] starts;
        bit ok;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(posedge clk); #1;
        n_cmp++;
        if (count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_count got=%0d want=1", count);
        end
        #1;
        wr_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            starts[k] = start;
        end
        n_cmp++;
        if (starts !== 3'b100) begin
            n_fail++;
            $display("FAIL single_start_timing got=%b want=100", starts);
        end
        n_cmp++;
        if (tx_data !== 8'hA5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data got=%h busy=%b want=a5 busy=1", tx_data, busy);
        end
        #1;
        wait_done(sb + 1, 300, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + 1 || sent_q[sb] !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_sent ok=%b n=%0d want one byte a5", ok, sent_q.size() - sb);
        end
        n_cmp++;
        if (pulses - pb != 1 || data_err != db || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_end pulses=%0d derr=%0d empty=%b want 1/0/1",
                     pulses - pb, data_err - db, empty);
        end
    endtask

    task automatic test_burst();
        logic [7:0] b [4] = '{8'h41, 8'h31, 8'h2B, 8'h0A};
        int sb = sent_q.size();
        int pb = pulses;
        int rb = rise_q.size();
        int eb = end_q.size();
        bit ok;
        wr_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_data = b[k];
            @(posedge clk); #2;
        end
        wr_en = 1'b0;
        wait_done(sb + 4, 600, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + 4 || pulses - pb != 4 || rise_q.size() - rb != 4) begin
            n_fail++;
            $display("FAIL burst_counts ok=%b sent=%0d pulses=%0d rises=%0d want 4/4/4",
                     ok, sent_q.size() - sb, pulses - pb, rise_q.size() - rb);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (sent_q.size() <= sb + k || sent_q[sb + k] !== b[k]) begin
                n_fail++;
                $display("FAIL burst_order idx=%0d want=%h", k, b[k]);
            end
        end
        for (int k = 1; k < 4; k++) begin
            n_cmp++;
            if (rise_q.size() <= rb + k || end_q.size() < eb + k ||
                rise_q[rb + k] - end_q[eb + k - 1] < GapCycles) begin
                n_fail++;
                $display("FAIL burst_gap frame=%0d gap too short or missing, want >=%0d",
                         k, GapCycles);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [17];
        int sb = sent_q.size();
        int pb = pulses;
        bit ok;
        hold_low = 1'b1;
        @(posedge clk); #2;
        wr_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            b[i] = 8'($urandom);
            wr_data = b[i];
            @(posedge clk); #1;
            if (i == 0) begin
                n_cmp++;
                if (count !== 5'd1 || empty !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_first count=%0d empty=%b want 1/0", count, empty);
                end
            end
            if (i == 15) begin
                n_cmp++;
                if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovf_full count=%0d full=%b ovf=%b want 16/1/0",
                             count, full, overflow);
                end
            end
            if (i == 16) begin
                n_cmp++;
                if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_drop count=%0d full=%b ovf=%b want 16/1/1",
                             count, full, overflow);
                end
            end
            #1;
        end
        wr_en = 1'b0;
        clr_ov = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got=%b want=0", overflow);
        end
        #1;
        clr_ov = 1'b0;
        hold_low = 1'b0;
        wait_done(sb + 16, 2000, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + 16 || pulses - pb != 16) begin
            n_fail++;
            $display("FAIL ovf_sent ok=%b sent=%0d pulses=%0d want 16/16",
                     ok, sent_q.size() - sb, pulses - pb);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (sent_q.size() <= sb + i || sent_q[sb + i] !== b[i]) begin
                n_fail++;
                $display("FAIL ovf_order idx=%0d want=%h", i, b[i]);
            end
        end
    endtask

    task automatic test_ack_timeout();
        logic [7:0] b = 8'($urandom);
        int sb = sent_q.size();
        int pb = pulses;
        int rb = rise_q.size();
        int nr;
        bit ok;
        ignore_start = 1'b1;
        wr_en = 1'b1;
        wr_data = b;
        @(posedge clk); #2;
        wr_en = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        ignore_start = 1'b0;
        wait_done(sb + 1, 300, ok);
        nr = rise_q.size() - rb;
        n_cmp++;
        if (!ok || nr < 2) begin
            n_fail++;
            $display("FAIL ack_rearm ok=%b rises=%0d want >=2", ok, nr);
        end
        for (int k = 1; k < nr; k++) begin
            n_cmp++;
            if (rise_q[rb + k] - rise_q[rb + k - 1] != AckTimeout + 1) begin
                n_fail++;
                $display("FAIL ack_period got=%0d want=%0d",
                         rise_q[rb + k] - rise_q[rb + k - 1], AckTimeout + 1);
            end
        end
        n_cmp++;
        if (sent_q.size() != sb + 1 || sent_q[sb] !== b || pulses - pb != 1) begin
            n_fail++;
            $display("FAIL ack_once sent=%0d pulses=%0d want one byte %h, one pulse",
                     sent_q.size() - sb, pulses - pb, b);
        end
    endtask

    task automatic test_simul_one();
        logic [7:0] x = 8'($urandom);
        logic [7:0] y = 8'($urandom);
        int sb = sent_q.size();
        int pb = pulses;
        bit ok;
        hold_low = 1'b1;
        @(posedge clk); #2;
        wr_en = 1'b1;
        wr_data = x;
        @(posedge clk); #2;
        hold_low = 1'b0;
        wr_data = y;
        @(posedge clk); #1;
        n_cmp++;
        if (count !== 5'd1 || empty !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL simul1_count count=%0d empty=%b busy=%b want 1/0/1",
                     count, empty, busy);
        end
        #1;
        wr_en = 1'b0;
        wait_done(sb + 2, 400, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + 2 || sent_q[sb] !== x || sent_q[sb + 1] !== y ||
            pulses - pb != 2) begin
            n_fail++;
            $display("FAIL simul1_order ok=%b sent=%0d pulses=%0d want %h,%h",
                     ok, sent_q.size() - sb, pulses - pb, x, y);
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] b [16];
        int sb = sent_q.size();
        bit ok;
        hold_low = 1'b1;
        @(posedge clk); #2;
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b[i] = 8'($urandom);
            wr_data = b[i];
            @(posedge clk); #2;
        end
        // Pop, dropped push and overflow clear all land on the same edge.
        hold_low = 1'b0;
        wr_data = 8'hEE;
        clr_ov = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL simul16 count=%0d ovf=%b full=%b want 15/1/0", count, overflow, full);
        end
        #1;
        wr_en = 1'b0;
        @(posedge clk); #2;
        clr_ov = 1'b0;
        wait_done(sb + 16, 2000, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + 16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL simul16_sent ok=%b sent=%0d ovf=%b want 16/0",
                     ok, sent_q.size() - sb, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (sent_q.size() <= sb + i || sent_q[sb + i] !== b[i]) begin
                n_fail++;
                $display("FAIL simul16_order idx=%0d want=%h", i, b[i]);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0] exp_q[$];
        int sb = sent_q.size();
        int pb = pulses;
        int db = data_err;
        bit ok;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(8'($urandom));
            wr_en = 1'b1;
            wr_data = exp_q[i];
            @(posedge clk); #2;
            wr_en = 1'b0;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #2;
        end
        wait_done(sb + n, 2000, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + n || pulses - pb != n || data_err != db ||
            overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_counts ok=%b sent=%0d pulses=%0d derr=%0d ovf=%b want %0d/%0d/0/0",
                     ok, sent_q.size() - sb, pulses - pb, data_err - db, overflow, n, n);
        end
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (sent_q.size() <= sb + i || sent_q[sb + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_order idx=%0d want=%h", i, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_busy();
        int sb;
        int pb;
        bit ok;
        wr_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_data = 8'($urandom);
            @(posedge clk); #2;
        end
        wr_en = 1'b0;
        sb = sent_q.size();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (frame_left > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (!ok || busy !== 1'b1 || count !== 5'd3) begin
            n_fail++;
            $display("FAIL rstb_pre ok=%b busy=%b count=%0d want 1/1/3", ok, busy, count);
        end
        pb = pulses;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({start, tx_data, count, empty, sent_pulse, busy} !==
            {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rstb_now start=%b data=%h count=%0d empty=%b pulse=%b busy=%b",
                     start, tx_data, count, empty, sent_pulse, busy);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        n_cmp++;
        if (pulses != pb || busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rstb_quiet pulses=%0d busy=%b empty=%b want 0/0/1",
                     pulses - pb, busy, empty);
        end
        sb = sent_q.size();
        wr_en = 1'b1;
        wr_data = 8'h5A;
        @(posedge clk); #2;
        wr_en = 1'b0;
        wait_done(sb + 1, 300, ok);
        n_cmp++;
        if (!ok || sent_q.size() != sb + 1 || sent_q[sb] !== 8'h5A || pulses - pb != 1) begin
            n_fail++;
            $display("FAIL rstb_after ok=%b sent=%0d pulses=%0d want one byte 5a",
                     ok, sent_q.size() - sb, pulses - pb);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_ack_timeout();
        test_simul_one();
        test_simul_full();
        for (int r = 0; r < 3; r++) test_random(6 + r * 3);
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
